// File: rtl/issue_pkg.sv
// Shared types for the issue scheduler: buffer entry layout,
// index/tag widths and unit encoding.
package issue_pkg;

    localparam int BUF_SIZE = 16;
    localparam int N_UNITS  = 4;
    localparam int IDX_W    = $clog2(BUF_SIZE);

    typedef logic [IDX_W-1:0] index_t;
    typedef logic [5:0]       spectag_t;

    typedef enum logic [1:0] {
        S_NOT_EXECUTED = 2'd0,
        S_EXECUTING    = 2'd1,
        S_DONE         = 2'd2
    } e_state_t;

    typedef enum logic [1:0] {
        U_ALU    = 2'd0,
        U_BRANCH = 2'd1,
        U_LOAD   = 2'd2,
        U_STORE  = 2'd3
    } unit_t;

    typedef struct packed {
        e_state_t    e_state;
        unit_t       unit;
        logic        J_rdy;
        logic        K_rdy;
        spectag_t    speculative_tag;
        logic [4:0]  dest;
        logic [31:0] pc;
    } entry_t;

endpackage

// File: rtl/issue_scheduler_if.sv
// Issue handshake between scheduler (master) and the four units (slave).
// Slot order: 0=ALU 1=BRANCH 2=LOAD 3=STORE.
interface issue_scheduler_if;
    import issue_pkg::*;

    logic   [N_UNITS-1:0] issue_valid;
    index_t [N_UNITS-1:0] issue_index;
    entry_t [N_UNITS-1:0] issue_entry;
    logic   [N_UNITS-1:0] issue_fire;
    logic   [N_UNITS-1:0] unit_ready;

    modport master (
        output issue_valid, issue_index, issue_entry, issue_fire,
        input  unit_ready
    );

    modport slave (
        input  issue_valid, issue_index, issue_entry, issue_fire,
        output unit_ready
    );

endinterface

// File: rtl/issue_scheduler.sv
// Picks the oldest ready entry per unit class and holds it in a per-unit
// slot until the unit accepts it; stores in order, loads behind stores,
// flush squashes slots by speculative tag.
// Ports: clk, rst_n (async low), entries (buffer, low index = older),
// flush/flush_spectag, iss (issue handshake, master), perf_issued/perf_stall.
// Optional: define ISSUE_PERF_CNT_EN to build the per-unit counters.
module issue_scheduler
    import issue_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  entry_t [BUF_SIZE-1:0]     entries,
    input  logic                      flush,
    input  spectag_t                  flush_spectag,
    issue_scheduler_if.master         iss,
    output logic [N_UNITS-1:0][31:0]  perf_issued,
    output logic [N_UNITS-1:0][31:0]  perf_stall
);

    logic   [N_UNITS-1:0]  valid_q;
    index_t [N_UNITS-1:0]  idx_q;
    entry_t [N_UNITS-1:0]  ent_q;

    logic   [BUF_SIZE-1:0] held;
    logic   [N_UNITS-1:0]  found;
    index_t [N_UNITS-1:0]  pick;
    logic   [N_UNITS-1:0]  squash;
    logic   [N_UNITS-1:0]  fire;
    logic   [N_UNITS-1:0]  load;
    logic   [N_UNITS-1:0]  clear;

    // An entry sitting in any valid slot must not be picked again.
    always_comb begin
        held = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            for (int u = 0; u < N_UNITS; u++) begin
                if (valid_q[u] && idx_q[u] == index_t'(i))
                    held[i] = 1'b1;
            end
        end
    end

    // Single oldest-first scan. store_seen marks the oldest pending
    // store (only it may issue); load_block goes high once any older
    // pending or slot-held store has been passed.
    always_comb begin : sel
        entry_t e;
        logic   pend;
        logic   go;
        logic   store_seen;
        logic   load_block;
        e          = '0;
        pend       = 1'b0;
        go         = 1'b0;
        store_seen = 1'b0;
        load_block = 1'b0;
        found      = '0;
        pick       = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            e    = entries[i];
            pend = (e.e_state == S_NOT_EXECUTED);
            go   = pend && e.J_rdy && e.K_rdy && !held[i];
            unique case (e.unit)
                U_ALU: begin
                    if (go && !found[0]) begin
                        found[0] = 1'b1;
                        pick[0]  = index_t'(i);
                    end
                end
                U_BRANCH: begin
                    if (go && !found[1]) begin
                        found[1] = 1'b1;
                        pick[1]  = index_t'(i);
                    end
                end
                U_LOAD: begin
                    if (go && !found[2] && !load_block) begin
                        found[2] = 1'b1;
                        pick[2]  = index_t'(i);
                    end
                end
                U_STORE: begin
                    if (pend && !store_seen) begin
                        store_seen = 1'b1;
                        if (go) begin
                            found[3] = 1'b1;
                            pick[3]  = index_t'(i);
                        end
                    end
                end
                default: ;
            endcase
            if ((pend && e.unit == U_STORE) ||
                (valid_q[3] && idx_q[3] == index_t'(i)))
                load_block = 1'b1;
        end
    end

    // A squashed slot never reports fire; survivors may still fire
    // during a flush but nothing reloads that cycle.
    always_comb begin
        squash = '0;
        fire   = '0;
        load   = '0;
        clear  = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            squash[u] = flush && valid_q[u] &&
                        |(ent_q[u].speculative_tag & flush_spectag);
            fire[u]   = valid_q[u] && iss.unit_ready[u] && !squash[u];
            load[u]   = !flush && (!valid_q[u] || fire[u]) && found[u];
            clear[u]  = squash[u] || fire[u];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            idx_q   <= '0;
            ent_q   <= '0;
        end else begin
            for (int u = 0; u < N_UNITS; u++) begin
                if (load[u]) begin
                    valid_q[u] <= 1'b1;
                    idx_q[u]   <= pick[u];
                    ent_q[u]   <= entries[pick[u]];
                end else if (clear[u]) begin
                    valid_q[u] <= 1'b0;
                end
            end
        end
    end

    assign iss.issue_valid = valid_q;
    assign iss.issue_index = idx_q;
    assign iss.issue_entry = ent_q;
    assign iss.issue_fire  = fire;

`ifdef ISSUE_PERF_CNT_EN
    logic [N_UNITS-1:0][31:0] issued_q;
    logic [N_UNITS-1:0][31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            for (int u = 0; u < N_UNITS; u++) begin
                issued_q[u] <= issued_q[u] + {31'd0, fire[u]};
                stall_q[u]  <= stall_q[u] +
                    {31'd0, valid_q[u] & ~iss.unit_ready[u]};
            end
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`else
    assign perf_issued = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios plus a
// randomized run against a rule-level model of the slots and buffer.
module tb_issue_scheduler;
    import issue_pkg::*;

`ifdef ISSUE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    entry_t [BUF_SIZE-1:0] entries;
    logic flush;
    spectag_t flush_spectag;
    logic [N_UNITS-1:0][31:0] perf_issued;
    logic [N_UNITS-1:0][31:0] perf_stall;

    issue_scheduler_if iss();

    issue_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .entries       (entries),
        .flush         (flush),
        .flush_spectag (flush_spectag),
        .iss           (iss),
        .perf_issued   (perf_issued),
        .perf_stall    (perf_stall)
    );

    always #5 clk = ~clk;

    // model state
    logic [3:0]  m_valid;
    index_t      m_idx [4];
    entry_t      m_ent [4];
    logic [31:0] m_issued [4];
    logic [31:0] m_stall [4];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic entry_t mk(unit_t un, logic j, logic k,
                                  spectag_t t);
        entry_t e;
        e = '0;
        e.e_state = S_NOT_EXECUTED;
        e.unit = un;
        e.J_rdy = j;
        e.K_rdy = k;
        e.speculative_tag = t;
        e.dest = 5'($urandom);
        e.pc = $urandom;
        return e;
    endfunction

    function automatic logic [3:0] m_fire_f();
        logic [3:0] f;
        for (int u = 0; u < 4; u++)
            f[u] = m_valid[u] && iss.unit_ready[u] &&
                   !(flush && |(m_ent[u].speculative_tag & flush_spectag));
        return f;
    endfunction

    function automatic bit held(int i);
        for (int u = 0; u < 4; u++)
            if (m_valid[u] && int'(m_idx[u]) == i) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pending(int i);
        return entries[i].e_state == S_NOT_EXECUTED;
    endfunction

    function automatic bit can_go(int i);
        return pending(i) && entries[i].J_rdy && entries[i].K_rdy && !held(i);
    endfunction

    function automatic bit store_pending(int i);
        return pending(i) && entries[i].unit == U_STORE;
    endfunction

    // Oldest eligible index for unit u, or -1.
    function automatic int pick(int u);
        bit blocked;
        if (u == 3) begin
            for (int i = 0; i < BUF_SIZE; i++)
                if (store_pending(i)) return can_go(i) ? i : -1;
            return -1;
        end
        for (int i = 0; i < BUF_SIZE; i++) begin
            if (entries[i].unit == unit_t'(u) && can_go(i)) begin
                if (u != 2) return i;
                blocked = 1'b0;
                for (int j = 0; j < i; j++)
                    if (store_pending(j) ||
                        (m_valid[3] && int'(m_idx[3]) == j))
                        blocked = 1'b1;
                if (!blocked) return i;
            end
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_valid = '0;
        for (int u = 0; u < 4; u++) begin
            m_idx[u] = '0;
            m_ent[u] = '0;
            m_issued[u] = '0;
            m_stall[u] = '0;
        end
    endtask

    // Advance one clock: model follows the edge, the buffer marks fired
    // entries executing and kills flushed ones just after the edge.
    task automatic tick();
        logic [3:0] f;
        logic [3:0] sq;
        logic [3:0] rd;
        int p [4];
        index_t fidx [4];
        logic fl;
        spectag_t tag;
        f = m_fire_f();
        fl = flush;
        tag = flush_spectag;
        rd = iss.unit_ready;
        for (int u = 0; u < 4; u++) begin
            p[u] = pick(u);
            sq[u] = fl && m_valid[u] &&
                    |(m_ent[u].speculative_tag & tag);
        end
        @(posedge clk);
        for (int u = 0; u < 4; u++) begin
            m_issued[u] += {31'd0, f[u]};
            m_stall[u] += {31'd0, m_valid[u] & ~rd[u]};
            fidx[u] = m_idx[u];
            if (sq[u]) begin
                m_valid[u] = 1'b0;
            end else if (!fl && (!m_valid[u] || f[u]) && p[u] >= 0) begin
                m_valid[u] = 1'b1;
                m_idx[u] = index_t'(p[u]);
                m_ent[u] = entries[p[u]];
            end else if (f[u]) begin
                m_valid[u] = 1'b0;
            end
        end
        #1;
        for (int u = 0; u < 4; u++)
            if (f[u]) entries[fidx[u]].e_state = S_EXECUTING;
        if (fl)
            for (int i = 0; i < BUF_SIZE; i++)
                if (pending(i) && |(entries[i].speculative_tag & tag))
                    entries[i].e_state = S_DONE;
    endtask

    task automatic clear_buf();
        for (int i = 0; i < BUF_SIZE; i++) begin
            entries[i] = mk(U_ALU, 1'b0, 1'b0, 6'd0);
            entries[i].e_state = S_DONE;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_buf();
        iss.unit_ready = '0;
        flush = 1'b0;
        flush_spectag = '0;
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_buf();
        iss.unit_ready = '0;
        flush = 1'b0;
        flush_spectag = '0;
        model_clear();
        #3;
        n_tests++;
        if (iss.issue_valid !== 4'b0 || iss.issue_index !== '0 ||
            iss.issue_entry !== '0) begin
            n_fail++;
            $display("FAIL reset_slots: valid=%b idx=%h, want 0/0",
                     iss.issue_valid, iss.issue_index);
        end
        n_tests++;
        if (perf_issued !== '0 || perf_stall !== '0) begin
            n_fail++;
            $display("FAIL reset_perf: issued=%h stall=%h, want 0",
                     perf_issued, perf_stall);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_alu_order();
        do_reset();
        entries[3] = mk(U_ALU, 1'b1, 1'b1, 6'd0);
        entries[7] = mk(U_ALU, 1'b1, 1'b1, 6'd0);
        iss.unit_ready = 4'b0001;
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_latency: valid=%b, want 0", iss.issue_valid[0]);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[0] !== 1'b1 || iss.issue_index[0] !== 4'd3 ||
            iss.issue_fire[0] !== 1'b1 || iss.issue_entry[0] !== entries[3]) begin
            n_fail++;
            $display("FAIL alu_first: v=%b idx=%0d fire=%b, want 1/3/1",
                     iss.issue_valid[0], iss.issue_index[0], iss.issue_fire[0]);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[0] !== 1'b1 || iss.issue_index[0] !== 4'd7 ||
            iss.issue_fire[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_second: v=%b idx=%0d fire=%b, want 1/7/1",
                     iss.issue_valid[0], iss.issue_index[0], iss.issue_fire[0]);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[0] !== 1'b0 ||
            perf_issued[0] !== (PERF ? 32'd2 : 32'd0)) begin
            n_fail++;
            $display("FAIL alu_drain: v=%b issued=%0d, want 0/%0d",
                     iss.issue_valid[0], perf_issued[0], PERF ? 2 : 0);
        end
    endtask

    task automatic test_branch_stall();
        do_reset();
        entries[5] = mk(U_BRANCH, 1'b1, 1'b1, 6'd0);
        @(negedge clk);
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (iss.issue_valid[1] !== 1'b1 || iss.issue_index[1] !== 4'd5 ||
                iss.issue_fire[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL br_hold%0d: v=%b idx=%0d fire=%b, want 1/5/0",
                         k, iss.issue_valid[1], iss.issue_index[1],
                         iss.issue_fire[1]);
            end
            tick();
        end
        iss.unit_ready[1] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (iss.issue_fire[1] !== 1'b1 || iss.issue_index[1] !== 4'd5 ||
            perf_stall[1] !== (PERF ? 32'd4 : 32'd0)) begin
            n_fail++;
            $display("FAIL br_fire: fire=%b idx=%0d stall=%0d, want 1/5/%0d",
                     iss.issue_fire[1], iss.issue_index[1], perf_stall[1],
                     PERF ? 4 : 0);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL br_clear: v=%b, want 0", iss.issue_valid[1]);
        end
    endtask

    task automatic test_store_load();
        do_reset();
        entries[2] = mk(U_STORE, 1'b0, 1'b1, 6'd0);
        entries[6] = mk(U_LOAD, 1'b1, 1'b1, 6'd0);
        entries[9] = mk(U_STORE, 1'b1, 1'b1, 6'd0);
        iss.unit_ready = 4'b1100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[3:2] !== 2'b00) begin
            n_fail++;
            $display("FAIL mem_blocked: v=%b, want 00", iss.issue_valid[3:2]);
        end
        entries[2].J_rdy = 1'b1;
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[3:2] !== 2'b10 || iss.issue_index[3] !== 4'd2 ||
            iss.issue_fire[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL st_first: v=%b idx=%0d, want 10/2",
                     iss.issue_valid[3:2], iss.issue_index[3]);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[3:2] !== 2'b00) begin
            n_fail++;
            $display("FAIL st_gap: v=%b, want 00", iss.issue_valid[3:2]);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[3:2] !== 2'b11 || iss.issue_index[2] !== 4'd6 ||
            iss.issue_index[3] !== 4'd9) begin
            n_fail++;
            $display("FAIL ld_after: v=%b ld=%0d st=%0d, want 11/6/9",
                     iss.issue_valid[3:2], iss.issue_index[2],
                     iss.issue_index[3]);
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        entries[4] = mk(U_ALU, 1'b1, 1'b1, 6'b000010);
        entries[8] = mk(U_LOAD, 1'b1, 1'b1, 6'b000001);
        entries[10] = mk(U_ALU, 1'b1, 1'b1, 6'b000100);
        @(negedge clk);
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid !== 4'b0101 || iss.issue_index[0] !== 4'd4 ||
            iss.issue_index[2] !== 4'd8) begin
            n_fail++;
            $display("FAIL fl_setup: v=%b, want 0101", iss.issue_valid);
        end
        flush = 1'b1;
        flush_spectag = 6'b000010;
        tick();
        flush = 1'b0;
        flush_spectag = '0;
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid !== 4'b0100 || iss.issue_index[2] !== 4'd8) begin
            n_fail++;
            $display("FAIL fl_squash: v=%b ld=%0d, want 0100/8",
                     iss.issue_valid, iss.issue_index[2]);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[0] !== 1'b1 || iss.issue_index[0] !== 4'd10) begin
            n_fail++;
            $display("FAIL fl_resume: v=%b idx=%0d, want 1/10",
                     iss.issue_valid[0], iss.issue_index[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        entries[0] = mk(U_ALU, 1'b1, 1'b1, 6'd0);
        entries[1] = mk(U_LOAD, 1'b1, 1'b1, 6'd0);
        entries[2] = mk(U_BRANCH, 1'b1, 1'b1, 6'd0);
        entries[3] = mk(U_STORE, 1'b1, 1'b1, 6'd0);
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL ar_full: v=%b, want 1111", iss.issue_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        n_tests++;
        if (iss.issue_valid !== 4'b0 || perf_issued !== '0 ||
            perf_stall !== '0) begin
            n_fail++;
            $display("FAIL ar_drop: v=%b stall=%h, want 0/0",
                     iss.issue_valid, perf_stall);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL ar_resume: v=%b, want 1111", iss.issue_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 3; i++)
            entries[i] = mk(U_ALU, 1'b1, 1'b1, 6'd0);
        iss.unit_ready = 4'b0001;
        tick();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (iss.issue_valid[0] !== 1'b1 || int'(iss.issue_index[0]) != k ||
                iss.issue_fire[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d: v=%b idx=%0d, want 1/%0d",
                         k, iss.issue_valid[0], iss.issue_index[0], k);
            end
            tick();
        end
        @(negedge clk);
        n_tests++;
        if (iss.issue_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: v=%b, want 0", iss.issue_valid[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            iss.unit_ready = 4'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            flush_spectag = 6'b1 << $urandom_range(0, 5);
            for (int i = 0; i < BUF_SIZE; i++) begin
                unique case (entries[i].e_state)
                    S_NOT_EXECUTED: begin
                        if ($urandom_range(0, 3) == 0) entries[i].J_rdy = 1'b1;
                        if ($urandom_range(0, 3) == 0) entries[i].K_rdy = 1'b1;
                    end
                    S_EXECUTING: begin
                        if ($urandom_range(0, 2) == 0) entries[i].e_state = S_DONE;
                    end
                    default: begin
                        if ($urandom_range(0, 3) == 0)
                            entries[i] = mk(unit_t'($urandom_range(0, 3)),
                                            1'($urandom_range(0, 1)),
                                            1'($urandom_range(0, 1)),
                                            6'b1 << $urandom_range(0, 5));
                    end
                endcase
            end
            @(negedge clk);
            n_tests++;
            if (iss.issue_valid !== m_valid || iss.issue_fire !== m_fire_f()) begin
                n_fail++;
                $display("FAIL rnd_vf c%0d: v=%b f=%b, want %b/%b", c,
                         iss.issue_valid, iss.issue_fire, m_valid, m_fire_f());
            end
            for (int u = 0; u < 4; u++) begin
                if (m_valid[u]) begin
                    n_tests++;
                    if (iss.issue_index[u] !== m_idx[u] ||
                        iss.issue_entry[u] !== m_ent[u]) begin
                        n_fail++;
                        $display("FAIL rnd_slot c%0d u%0d: idx=%0d, want %0d",
                                 c, u, iss.issue_index[u], m_idx[u]);
                    end
                end
                n_tests++;
                if (perf_issued[u] !== (PERF ? m_issued[u] : 32'd0) ||
                    perf_stall[u] !== (PERF ? m_stall[u] : 32'd0)) begin
                    n_fail++;
                    $display("FAIL rnd_perf c%0d u%0d: %0d/%0d, want %0d/%0d",
                             c, u, perf_issued[u], perf_stall[u],
                             PERF ? m_issued[u] : 0, PERF ? m_stall[u] : 0);
                end
            end
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_order();
        test_branch_stall();
        test_store_load();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Selects, once per cycle, the oldest operand-ready entry of each functional-unit class from the reservation/reorder buffer filled by dispatch, and holds it in a per-unit output slot until the unit accepts it. It sits between the entry buffer and the ALU, BRANCH, LOAD and STORE units. It owns the ready/accept handshake, store/load ordering and squashing of wrong-path issues on branch misprediction.

## Interface
- BUF_SIZE, 16, number of buffer entries; index_t width is clog2(BUF_SIZE)
- N_UNITS, 4, fixed unit count; slot 0=ALU, 1=BRANCH, 2=LOAD, 3=STORE (not overridable)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- entries  in  entry_t[BUF_SIZE]  current buffer contents; lower index is older
- unit_ready  in  1[4]  unit accepts an op this cycle
- flush  in  1  branch mispredict squash
- flush_spectag  in  spectag_t (6)  one-hot speculative slot being killed
- issue_valid  out  1[4]  slot holds an op for that unit
- issue_index  out  index_t[4]  buffer index of held op
- issue_entry  out  entry_t[4]  copy of the entry captured at selection
- issue_fire  out  1[4]  issue_valid & unit_ready; the buffer sets the entry to executing on this
- perf_issued  out  32[4]  per-unit accepted-op counter (see Configuration)
- perf_stall  out  32[4]  per-unit cycles with issue_valid & !unit_ready

## Operation
- Candidate for unit u: e_state==S_NOT_EXECUTED, Unit maps to u, J_rdy & K_rdy, and index != any slot's held index while that slot is valid.
- ALU/BRANCH: lowest-index candidate wins.
- STORE: only the lowest-index S_NOT_EXECUTED STORE entry overall may issue, and only if it is ready. Stores issue strictly in order.
- LOAD: a candidate is eligible only if no lower-index entry is a STORE in S_NOT_EXECUTED, or is currently held in slot 3.
- Slot load: slot u captures {index, entry} when (!issue_valid[u] | issue_fire[u]) and a candidate exists and !flush. Back-to-back issue is allowed.
- Slot clear: on issue_fire without a new candidate.
- Flush: any valid slot whose issue_entry.speculative_tag & flush_spectag != 0 is cleared at the edge. No slot loads in the flush cycle; surviving slots hold. issue_fire is still reported in the flush cycle for slots not squashed.
- A slot never reloads the same index it is firing in that cycle. That entry becomes executing next cycle.
- Reset: issue_valid=0, issue_index=0, issue_entry=0, perf counters=0. Assertion mid-transfer discards slot contents.

## Timing
- Selection is combinational from entries in cycle N. issue_valid rises at cycle N+1; minimum buffer-to-unit latency is 1 cycle.
- issue_valid, issue_index and issue_entry are stable while issue_valid & !unit_ready (no retraction except flush/reset).
- issue_fire is combinational from registered issue_valid and the unit_ready input.
- Throughput: one op per unit per cycle when unit_ready stays high.
- Counters wrap at 2^32-1 → 0.

## Configuration
- ISSUE_PERF_CNT_EN defined: perf_issued[u] increments on issue_fire[u]; perf_stall[u] increments on issue_valid[u] & !unit_ready[u].
- ISSUE_PERF_CNT_EN undefined: counter registers are not built; perf_issued and perf_stall are tied to 0.

## Test plan
- Entries 3 (ALU, ready) and 7 (ALU, ready), unit_ready[0]=1 → cycle+1: issue_index[0]=3, fire. Next cycle: index 7 (entry 3 now executing).
- unit_ready[1]=0 for 4 cycles with BRANCH at index 5 → issue_valid[1] held with index 5 stable. perf_stall[1]=4 with macro defined, 0 without. Fire on the 5th cycle.
- STORE at 2 (J_rdy=0), LOAD at 6 ready, STORE at 9 ready → no LOAD or STORE issue. When index 2 becomes ready, STORE 2 issues; LOAD 6 issues only after STORE 2 fires.
- Slots ALU (spectag 6'b000010) and LOAD (spectag 6'b000001) valid, flush=1 with flush_spectag=6'b000010 → ALU slot cleared, LOAD slot held, no new loads that cycle.
- rst_n low asynchronously mid-cycle with all four slots valid → all issue_valid drop immediately, counters read 0. After release, selection resumes next edge.
- ALU ready entries at 1, 2, 3 with unit_ready[0]=1 continuously → indices 1, 2, 3 issue on three consecutive cycles and no index repeats.
